// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM states and frame constants.
package uart_receiver_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Data bits per 8N1 frame.
    localparam int DATA_W = 8;

    // Default oversample ticks per bit period.
    localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bus: serial line in, parallel byte and strobes out.
//
// Strobe semantics: valid and frame_err are single-cycle pulses with no
// ready/backpressure. A consumer must capture data in the cycle valid is
// high; a later frame overwrites data unconditionally. The two strobes are
// mutually exclusive.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              busy;
    state_t            state;     // FSM state, exposed for debug/checkers

    // master: drives the line and consumes the parallel output
    modport master (output rx, input data, valid, frame_err, busy, state);
    // slave: the receiver itself
    modport slave  (input rx, output data, valid, frame_err, busy, state);

endinterface

// File: rtl/uart_receiver_rx_tick_gen.sv
// Oversample tick generator: divides clk by CLK_DIV, restartable.
module rx_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick is combinational on the terminal count
    assign tick = (cnt_q == TERM);

    // next count: wrap on terminal count, clear on restart
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    // divider register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizer, edge detect, oversampling FSM, shifter.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.slave bus
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_W - 1);

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic              fall;
    logic              tick, restart;
    state_t            state_q, state_d;
    logic [SW-1:0]     samp_q, samp_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // two-flop synchronizer plus edge-detect history, idle-high at reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    // FSM next state, counters, shifter and strobes
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    restart = 1'b1;
                    samp_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_q == SAMP_MID) begin
                        samp_d  = '0;
                        // a high line at mid start bit is a glitch, not a frame
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
                        data_d = shift_q;
                        if (rx_s_q) begin
                            // leave at mid stop bit to resync on the next start
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (CLK_DIV=4, OVERSAMPLE=16: 64 clk/bit).
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int BIT_CLKS = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] exp_q[$];   // bytes expected with valid
    logic [7:0] fe_q[$];    // bytes expected with frame_err

    uart_receiver_if bus ();

    uart_receiver #(.CLK_DIV(4), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // drive one 8N1 frame, caller aligned on a falling clk edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bit_clks, input bit push);
        if (push) begin
            if (stop_bit) exp_q.push_back(b);
            else          fe_q.push_back(b);
        end
        bus.rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // bounded wait for the scoreboard to drain
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fe_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pending_valid"}, exp_q.size(), 0);
        check({tag, "_pending_ferr"}, fe_q.size(), 0);
    endtask

    // output monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid) begin
                check("strobe_overlap", {31'b0, bus.frame_err}, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'b0, bus.valid}, 0);
                end else begin
                    check("valid_data", {24'b0, bus.data}, {24'b0, exp_q.pop_front()});
                end
            end
            if (bus.frame_err) begin
                if (fe_q.size() == 0) begin
                    check("spurious_frame_err", {31'b0, bus.frame_err}, 0);
                end else begin
                    check("ferr_data", {24'b0, bus.data}, {24'b0, fe_q.pop_front()});
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);

        // reset values
        check("rst_data", {24'b0, bus.data}, 0);
        check("rst_valid", {31'b0, bus.valid}, 0);
        check("rst_ferr", {31'b0, bus.frame_err}, 0);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b1;
        idle(10);

        // single good frame
        send_frame(8'h55, 1'b1, BIT_CLKS, 1'b1);
        check("t1_busy_low", {31'b0, bus.busy}, 0);
        idle(20);
        wait_drain("t1");
        check("t1_data_held", {24'b0, bus.data}, 32'h55);

        // back-to-back frames
        send_frame(8'hA3, 1'b1, BIT_CLKS, 1'b1);
        send_frame(8'h3C, 1'b1, BIT_CLKS, 1'b1);
        idle(20);
        wait_drain("t2");

        // false start: 12-clk glitch
        bus.rx = 1'b0;
        repeat (12) @(negedge clk);
        bus.rx = 1'b1;
        check("t3_busy_during", {31'b0, bus.busy}, 1);
        repeat (33) @(negedge clk);
        check("t3_busy_after", {31'b0, bus.busy}, 0);
        check("t3_state", 32'(bus.state), 32'(IDLE));
        idle(40);

        // framing error, held low, then recovery
        send_frame(8'hF0, 1'b0, BIT_CLKS, 1'b1);
        repeat (200) @(negedge clk);
        check("t4_wait_high", 32'(bus.state), 32'(WAIT_HIGH));
        check("t4_busy_held", {31'b0, bus.busy}, 1);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_back_idle", 32'(bus.state), 32'(IDLE));
        idle(20);
        wait_drain("t4a");
        send_frame(8'h0F, 1'b1, BIT_CLKS, 1'b1);
        idle(20);
        wait_drain("t4b");

        // +/-3% line rate
        send_frame(8'h00, 1'b1, 62, 1'b1);
        idle(30);
        send_frame(8'hFF, 1'b1, 62, 1'b1);
        idle(30);
        send_frame(8'h00, 1'b1, 66, 1'b1);
        idle(30);
        send_frame(8'hFF, 1'b1, 66, 1'b1);
        idle(30);
        wait_drain("t5");

        // reset in the middle of data bit 4; upper nibble high so no re-trigger
        fork
            send_frame(8'hF2, 1'b1, BIT_CLKS, 1'b0);
            begin
                repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("t6_rst_data", {24'b0, bus.data}, 0);
                check("t6_rst_busy", {31'b0, bus.busy}, 0);
                check("t6_rst_valid", {31'b0, bus.valid}, 0);
                check("t6_rst_state", 32'(bus.state), 32'(IDLE));
                rst = 1'b1;
            end
        join
        idle(40);
        check("t6_stays_idle", {31'b0, bus.busy}, 0);
        send_frame(8'h81, 1'b1, BIT_CLKS, 1'b1);
        idle(20);
        wait_drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
